// File: rtl/demux_1to2_buffered.sv
// Steers one producer word stream into two independently buffered consumer channels.
// Channel A feeds the register file, channel B the store/IO path; each has its own FIFO.

module demux_1to2_buffered_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic [CW-1:0]    count,
    output logic             not_full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW-1:0]    rptr_next;
    logic [CW-1:0]    count_next;
    logic [WIDTH-1:0] head_next;
    logic             pop;

    assign valid    = (count != '0);
    assign not_full = (count != FULL);
    assign pop      = valid && ready;

    // The output register is loaded with the word that will sit at the head after
    // this edge; a word being written into that very slot is forwarded from wdata.
    always_comb begin
        rptr_next  = pop ? rptr + 1'b1 : rptr;
        count_next = count;
        if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (pop && !push) begin
            count_next = count - 1'b1;
        end
        head_next = (push && (wptr == rptr_next)) ? wdata : mem[rptr_next];
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            data  <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            rptr  <= rptr_next;
            count <= count_next;
            // An emptied channel keeps showing its last word.
            if (count_next != '0) begin
                data <= head_next;
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && (count == FULL)));
    a_count_range: assert property (@(posedge clk) disable iff (!rst_n)
        count <= FULL);
    a_stable_head: assert property (@(posedge clk) disable iff (!rst_n)
        (valid && !ready) |=> (valid && $stable(data)));
endmodule

module demux_1to2_buffered #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] a_data,
    output logic [CW-1:0]    a_count,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [WIDTH-1:0] b_data,
    output logic [CW-1:0]    b_count
);
    // Handshake: a word moves on a rising edge when valid && ready are both high;
    // ready never looks at valid, and a same-cycle pop does not make room for a push.
    logic a_not_full;
    logic b_not_full;
    logic push_a;
    logic push_b;

    assign in_ready = in_sel ? b_not_full : a_not_full;
    assign push_a   = in_valid && in_ready && !in_sel;
    assign push_b   = in_valid && in_ready && in_sel;

    demux_1to2_buffered_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) u_fifo_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push_a),
        .wdata    (in_data),
        .ready    (a_ready),
        .valid    (a_valid),
        .data     (a_data),
        .count    (a_count),
        .not_full (a_not_full)
    );

    demux_1to2_buffered_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) u_fifo_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push_b),
        .wdata    (in_data),
        .ready    (b_ready),
        .valid    (b_valid),
        .data     (b_data),
        .count    (b_count),
        .not_full (b_not_full)
    );
endmodule

// File: tb/tb_demux_1to2_buffered.sv
// Directed bench for demux_1to2_buffered: per-channel expected queues filled on acceptance,
// drained by a monitor whenever a channel hands a word to its consumer.

module tb_demux_1to2_buffered;
    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic         in_sel;
    logic [W-1:0] in_data;
    logic         a_valid;
    logic         a_ready;
    logic [W-1:0] a_data;
    logic [1:0]   a_count;
    logic         b_valid;
    logic         b_ready;
    logic [W-1:0] b_data;
    logic [1:0]   b_count;

    logic [W-1:0] exp_a[$];
    logic [W-1:0] exp_b[$];
    int checks = 0;
    int errors = 0;

    demux_1to2_buffered dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_sel   (in_sel),
        .in_data  (in_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_data   (a_data),
        .a_count  (a_count),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_data   (b_data),
        .b_count  (b_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Presents a word and waits for acceptance; leaves in_valid high on return (posedge+1).
    task automatic push_word(input logic sel, input logic [W-1:0] data);
        bit done = 0;
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = data;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            if (in_ready) begin
                if (sel) exp_b.push_back(data);
                else     exp_a.push_back(data);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            errors++;
            $display("FAIL push_timeout: got no in_ready expected in_ready=1 for 0x%0h", data);
        end
    endtask

    task automatic push_one(input logic sel, input logic [W-1:0] data);
        push_word(sel, data);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: a transfer happens at the next rising edge when valid && ready.
    always @(negedge clk) begin
        if (rst_n && a_valid && a_ready) begin
            if (exp_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected: got 0x%0h expected no word", a_data);
            end else begin
                check("a_data", 32'(a_data), 32'(exp_a.pop_front()));
            end
        end
        if (rst_n && b_valid && b_ready) begin
            if (exp_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected: got 0x%0h expected no word", b_data);
            end else begin
                check("b_data", 32'(b_data), 32'(exp_b.pop_front()));
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sel   = 1'b0;
        in_data  = '0;
        a_ready  = 1'b0;
        b_ready  = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_a_valid", 32'(a_valid), 0);
        check("rst_b_valid", 32'(b_valid), 0);
        check("rst_a_count", 32'(a_count), 0);
        check("rst_b_count", 32'(b_count), 0);
        check("rst_a_data", 32'(a_data), 0);
        check("rst_b_data", 32'(b_data), 0);
        in_sel = 1'b0;
        #1 check("rst_ready_sel0", 32'(in_ready), 1);
        in_sel = 1'b1;
        #1 check("rst_ready_sel1", 32'(in_ready), 1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(2);

        // Single words through each channel with consumers ready
        a_ready = 1'b1;
        b_ready = 1'b1;
        push_one(1'b0, 16'h1234);
        check("lat_a_valid", 32'(a_valid), 1);
        check("lat_a_data", 32'(a_data), 32'h1234);
        push_one(1'b1, 16'hABCD);
        check("lat_b_valid", 32'(b_valid), 1);
        check("lat_b_data", 32'(b_data), 32'hABCD);
        idle(2);
        check("drain_a_count", 32'(a_count), 0);
        check("drain_b_count", 32'(b_count), 0);

        // A stalled; B still accepts
        a_ready = 1'b0;
        b_ready = 1'b0;
        push_one(1'b0, 16'h0001);
        push_one(1'b0, 16'h0002);
        check("full_a_count", 32'(a_count), 2);
        in_sel = 1'b0;
        #1 check("full_a_ready", 32'(in_ready), 0);
        push_one(1'b1, 16'h00B0);
        check("b_indep_count", 32'(b_count), 1);
        check("a_still_full", 32'(a_count), 2);
        a_ready = 1'b1;
        b_ready = 1'b1;
        idle(4);
        check("a_drained", 32'(a_count), 0);
        check("b_drained", 32'(b_count), 0);

        // Full channel: pop in the same cycle does not free space for the push
        a_ready = 1'b0;
        push_one(1'b0, 16'h0003);
        push_one(1'b0, 16'h0004);
        a_ready  = 1'b1;
        in_valid = 1'b1;
        in_sel   = 1'b0;
        in_data  = 16'h0005;
        @(negedge clk);
        check("nopass_ready", 32'(in_ready), 0);
        @(posedge clk);
        #1;
        check("nopass_count", 32'(a_count), 1);
        check("nopass_ready_next", 32'(in_ready), 1);
        push_one(1'b0, 16'h0005);
        check("nopass_after_push", 32'(a_count), 1);
        idle(3);
        check("nopass_drained", 32'(a_count), 0);

        // Streaming ten words through B; pointers wrap several times
        b_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            push_word(1'b1, 16'(16'h0010 + i));
            check("stream_b_count", 32'(b_count), 1);
        end
        in_valid = 1'b0;
        idle(3);
        check("stream_b_empty", 32'(b_count), 0);

        // Asynchronous reset with a word held in each channel
        a_ready = 1'b0;
        b_ready = 1'b0;
        push_one(1'b0, 16'h0A0A);
        push_one(1'b1, 16'h0B0B);
        check("pre_rst_a_count", 32'(a_count), 1);
        check("pre_rst_b_count", 32'(b_count), 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_a_valid", 32'(a_valid), 0);
        check("arst_b_valid", 32'(b_valid), 0);
        check("arst_a_count", 32'(a_count), 0);
        check("arst_b_count", 32'(b_count), 0);
        check("arst_a_data", 32'(a_data), 0);
        exp_a.delete();
        exp_b.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        a_ready = 1'b1;
        b_ready = 1'b1;
        idle(1);
        check("post_rst_a_valid", 32'(a_valid), 0);
        push_one(1'b0, 16'h5555);
        check("post_rst_a_data", 32'(a_data), 32'h5555);
        idle(3);

        check("left_in_exp_a", 32'(exp_a.size()), 0);
        check("left_in_exp_b", 32'(exp_b.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/demux_1to2_buffered.md
Name: demux_1to2_buffered

Overview:
- Inverse of the datapath 2:1 selector: one 16-bit producer stream is steered to one of two consumer channels, A or B, under a per-word select.
- Each channel has its own small FIFO, so a stalled consumer blocks only words destined for it.
- Sits between the ALU/load result path and the two write-back consumers: register file (A) and store/IO path (B).

Parameters:
- WIDTH, 16, data word width in bits.
- DEPTH, 2, entries per channel FIFO; power of 2, minimum 2.
- CW, $clog2(DEPTH+1), occupancy counter width (derived; not for override).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  producer has a word.
- in_ready  out  1  demux accepts the word this cycle.
- in_sel  in  1  destination: 0 = channel A, 1 = channel B. Qualified by in_valid.
- in_data  in  WIDTH  word to steer.
- a_valid  out  1  channel A FIFO head valid.
- a_ready  in  1  A consumer takes head.
- a_data  out  WIDTH  channel A head word.
- a_count  out  CW  channel A occupancy.
- b_valid  out  1  channel B FIFO head valid.
- b_ready  in  1  B consumer takes head.
- b_data  out  WIDTH  channel B head word.
- b_count  out  CW  channel B occupancy.

Behaviour:
- Reset: one clock, clk; asynchronous active-low reset, rst_n, asserted asynchronously, released synchronously by the upstream reset synchroniser. While rst_n=0: a_count=b_count=0, a_valid=b_valid=0, a_data=b_data=0, pointers 0, storage contents don't-care. Reset mid-operation discards all buffered words; no word is emitted after reset.
- in_ready is combinational: in_ready = (in_sel==0) ? (a_count != DEPTH) : (b_count != DEPTH).
  - No pass-through when full: a pop in the same cycle does not free space for a push.
  - in_ready does not depend on in_valid.
- Push: on a rising edge with in_valid && in_ready, in_data is written at the selected channel's write pointer. That pointer advances mod DEPTH and that count increments. The other channel is untouched.
- Pop, per channel X: x_valid = (x_count != 0). On a rising edge with x_valid && x_ready, the read pointer advances mod DEPTH and x_count decrements. x_ready while x_valid=0 has no effect.
- Simultaneous push and pop on the same channel (count between 1 and DEPTH-1): count is unchanged and both pointers advance.
- Simultaneous push to A and pop from B, or the reverse, are independent.
- x_data presents storage[read pointer] and is registered storage; it must be stable while x_valid && !x_ready.
- When a channel is empty, x_data holds its last value (0 after reset); consumers must ignore it.
- Latency: a word accepted at edge N is visible on x_valid/x_data after edge N (cycle N+1) if the channel was empty. Otherwise it appears after all earlier words for that channel.
- Ordering: FIFO order is preserved per channel. There is no ordering guarantee between channels.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. Full and empty are decided by count, never by pointer compare.
- Backpressure: the producer must hold in_data/in_sel stable while in_valid && !in_ready. The block does not check this.
- Count never exceeds DEPTH or goes below 0. Any attempt to break this is an RTL bug and must be covered by an assertion.

Test Plan:
- Reset then idle -> a_valid=b_valid=0, a_count=b_count=0, in_ready=1 for both in_sel values.
- Push 0x1234 sel=0, then 0xABCD sel=1, with both readys=1 -> a_data=0x1234 with a_valid=1 one cycle after acceptance; b_data=0xABCD the next cycle; counts return to 0.
- a_ready=0; push 0x0001, 0x0002 to A -> a_count=2 and in_ready=0 for sel=0.
  - In the same state, sel=1 push of 0x00B0 is accepted (b_count=1).
  - Then raise a_ready -> A drains 0x0001 then 0x0002 in order.
- Channel A full (DEPTH=2), a_ready=1 and in_valid sel=0 in the same cycle -> in_ready=0 that cycle, count goes to 1; next cycle in_ready=1.
- Streaming: 10 words 0x0010..0x0019 to B with b_ready=1 throughout -> b_count stays at 1 during steady state, pointers wrap, and the output sequence is exactly 0x0010..0x0019.
- Assert rst_n=0 mid-stream with both channels at count 1 -> both valids drop asynchronously, counts=0; the first word after release is the first new push.
